multiplication_clha: RTL and testbench
======================================

// Module: multiplication_clha
// PURPOSE
//  Sequential shift-add fixed-point multiplier; the datapath sibling of the
//  carry-lookahead divider in the ODE arithmetic unit. Operand and result
//  format: [15:3] 13-bit two's-complement mantissa, [2:0] unsigned scale s,
//  value = mantissa * 2^-s. Result is always emitted at scale 3.
//  Sign-magnitude iteration: 13 add/shift steps on one 16-bit CLA adder.
// PARAMETERS
//  N          16   operand/result width (only 16 supported)
//  SCALE_W    3    scale-field width
//  OUT_SCALE  3    scale written into P[2:0]
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   synchronous, active-high reset
//  start         in   1   request; sampled only in IDLE or DONE
//  multiplicand  in   N   operand A (format above)
//  multiplier    in   N   operand B (format above)
//  P             out  N   product (format above); valid while ready=1
//  ready         out  1   result valid; held until next accepted start
//  overFlow      out  1   result magnitude not representable; valid with ready
// BEHAVIOUR
//  - Reset: state=IDLE, P=0, ready=0, overFlow=0, all internal regs zero.
//    Reset mid-operation aborts; the next edge with start=1 begins anew.
//  - States: IDLE -> MUL (start) -> NORM (count==0) -> DONE.
//    DONE -> MUL on start (clears ready/overFlow same edge).
//  - Accept edge: latch |mA|,|mB| (13-bit magnitude, -4096 -> 4096),
//    sign = mA[12]^mB[12], ssum = sA+sB (4-bit, 0..14),
//    acc[31:0] = {16'b0, 3'b0, |mB|}, count = 13.
//  - MUL (13 edges): if acc[0], acc[31:16] += {3'b0,|mA|} via CLA (carry kept
//    as bit 32); then acc = {carry, acc[31:1]}; count--.
//  - NORM (1 edge): sh = ssum - OUT_SCALE (-3..11); mag = sh>=0 ?
//    acc>>sh (truncate toward zero) : acc<<(-sh). If mag>=4096 -> overFlow=1,
//    P=0. Else P = {sign ? -mag[12:0] : mag[12:0], OUT_SCALE}; ready=1.
//    Zero product -> P = 16'h0003, no negative zero.
//  - Latency: start sampled at edge k -> P/ready/overFlow registered at edge
//    k+14. One op in flight; start while in MUL/NORM is ignored; operand
//    changes after the accept edge have no effect.
//  - -4096 * any non-zero operand with ssum<=3 is flagged overflow (no
//    asymmetric range; |result|<=4095 only).
// STRUCTURE
//  - Shared header (`include): N, SCALE_W, MAG_W=13, OUT_SCALE, state
//    encodings ST_IDLE/ST_MUL/ST_NORM/ST_DONE (2-bit).
//  - One sub-module: existing carry_lookahead_adder_16bit, cin=0, used for the
//    MUL accumulate; the final negate in NORM is plain RTL.
//  - Normalising shifter is combinational inside NORM; no extra instance.
// TESTING
//  1. 0x00A3 (2.5) x 0x0063 (1.5), start 1 cycle -> edge k+14: P=0x00F3
//     (3.75), ready=1, overFlow=0; ready low edges k+1..k+13.
//  2. 0xFF63 (-2.5) x 0x0063 -> P=0xFF13 (-3.75); swap signs both -> 0x00F3.
//  3. Scale mix: 0x0018 (3,s0) x 0x0013 (0.25) -> P=0x0033; 0x0018 x 0x0028
//     (5,s0) -> P=0x03C3 (left-shift path).
//  4. 0x0320 (100) x 0x0320 -> overFlow=1, P=0x0000, ready=1.
//  5. 0x0000 x 0x7FF8 -> P=0x0003, overFlow=0; 0xFFF8 (-1) x 0x0000 -> 0x0003.
//  6. Start, pulse start again at k+5 (ignored), reset at k+6 -> P=0, ready=0
//     at k+7; new start at k+8 with test-1 operands -> P=0x00F3 at k+22.

Source files
------------

// File: rtl/multiplication_clha_pkg.sv
// multiplication_clha_pkg: shared widths, state encoding and magnitude helper
package multiplication_clha_pkg;
  localparam int DEF_N = 16;
  localparam int DEF_SCALE_W = 3;
  localparam int DEF_OUT_SCALE = 3;
  localparam int MAG_W = 13;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_NORM, ST_DONE} state_t;
  // -4096 maps to 13'h1000, which reads as +4096 when treated as unsigned
  function automatic logic [MAG_W-1:0] mag_of(input logic [MAG_W-1:0] m);
    return m[MAG_W-1] ? -m : m;
  endfunction
endpackage

// File: rtl/multiplication_clha_cla.sv
// carry_lookahead_adder_16bit: 16-bit adder built from four 4-bit lookahead groups
module carry_lookahead_adder_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  logic [15:0] w_g, w_p;
  logic [16:0] w_c;
  logic [3:0]  w_gg, w_gp;
  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;
  always_comb begin
    w_c = '0;
    w_gg = '0;
    w_gp = '0;
    w_c[0] = i_cin;
    for (int j = 0; j < 4; j++) begin
      w_gp[j] = &w_p[4*j +: 4];
      w_gg[j] = w_g[4*j+3] | (w_p[4*j+3] & w_g[4*j+2]) | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
              | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
      for (int i = 1; i < 4; i++)
        w_c[4*j+i] = w_g[4*j+i-1] | (w_p[4*j+i-1] & w_c[4*j+i-1]);
      w_c[4*j+4] = w_gg[j] | (w_gp[j] & w_c[4*j]);
    end
  end
  assign o_sum  = w_p ^ w_c[15:0];
  assign o_cout = w_c[16];
endmodule

// File: rtl/multiplication_clha.sv
// multiplication_clha: sequential sign-magnitude shift-add fixed-point multiplier
// Operands/result: [15:3] two's-complement mantissa, [2:0] scale; result at OUT_SCALE.
module multiplication_clha
  import multiplication_clha_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int SCALE_W   = DEF_SCALE_W,
  parameter int OUT_SCALE = DEF_OUT_SCALE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] multiplicand,
  input  logic [N-1:0] multiplier,
  output logic [N-1:0] P,
  output logic         ready,
  output logic         overFlow
);
  localparam int ACC_W = 2 * N;
  state_t              r_state;
  logic [ACC_W-1:0]    r_acc;
  logic [MAG_W-1:0]    r_ma;
  logic                r_sign;
  logic [SCALE_W:0]    r_ssum;
  logic [3:0]          r_count;
  logic [MAG_W-1:0]    w_ma, w_mb, w_mant;
  logic [N-1:0]        w_sum;
  logic                w_cout, w_ovf;
  logic [ACC_W-1:0]    w_next, w_prod, w_mag;
  logic signed [SCALE_W+1:0] w_sh;
  logic [SCALE_W+1:0]  w_shn;
  assign w_ma = mag_of(multiplicand[N-1:SCALE_W]);
  assign w_mb = mag_of(multiplier[N-1:SCALE_W]);
  carry_lookahead_adder_16bit u_cla (
    .i_a    (r_acc[ACC_W-1:N]),
    .i_b    ({{(N-MAG_W){1'b0}}, r_ma}),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );
  assign w_next = r_acc[0] ? {w_cout, w_sum, r_acc[N-1:1]} : {1'b0, r_acc[ACC_W-1:1]};
  // after MAG_W shifts the product sits N-MAG_W bits above the LSB
  assign w_prod = r_acc >> (N - MAG_W);
  assign w_sh   = $signed({1'b0, r_ssum}) - $signed((SCALE_W+2)'(OUT_SCALE));
  assign w_shn  = -w_sh;
  assign w_mag  = w_sh[SCALE_W+1] ? w_prod << w_shn : w_prod >> $unsigned(w_sh);
  assign w_ovf  = |w_mag[ACC_W-1:MAG_W-1];
  assign w_mant = r_sign ? -w_mag[MAG_W-1:0] : w_mag[MAG_W-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_ma     <= '0;
      r_sign   <= 1'b0;
      r_ssum   <= '0;
      r_count  <= '0;
      P        <= '0;
      ready    <= 1'b0;
      overFlow <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: if (start) begin
          r_ma     <= w_ma;
          r_sign   <= multiplicand[N-1] ^ multiplier[N-1];
          r_ssum   <= {1'b0, multiplicand[SCALE_W-1:0]} + {1'b0, multiplier[SCALE_W-1:0]};
          r_acc    <= ACC_W'(w_mb);
          r_count  <= 4'(MAG_W);
          ready    <= 1'b0;
          overFlow <= 1'b0;
          r_state  <= ST_MUL;
        end
        ST_MUL: begin
          r_acc   <= w_next;
          r_count <= r_count - 4'd1;
          r_state <= r_count == 4'd1 ? ST_NORM : ST_MUL;
        end
        ST_NORM: begin
          P        <= w_ovf ? '0 : {w_mant, SCALE_W'(OUT_SCALE)};
          overFlow <= w_ovf;
          ready    <= 1'b1;
          r_state  <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiplication_clha.sv
// tb_multiplication_clha: table-driven and scoreboarded checks of the fixed-point multiplier
module tb_multiplication_clha;
  typedef struct { logic [15:0] a, b, p; logic ovf; } vec_t;
  typedef struct { logic [15:0] p; logic ovf; } exp_t;
  logic clk, reset, start, ready, overflow;
  logic [15:0] mcand, mplier, p;
  int errors = 0, checks = 0;
  exp_t sb[$];
  vec_t tv[13];
  multiplication_clha dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .P            (p),
    .ready        (ready),
    .overFlow     (overflow)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    int ma, mb, sh;
    longint pm, m;
    logic [31:0] r;
    exp_t e;
    ma = int'($signed(a[15:3]));
    mb = int'($signed(b[15:3]));
    pm = longint'(ma < 0 ? -ma : ma) * longint'(mb < 0 ? -mb : mb);
    sh = int'(a[2:0]) + int'(b[2:0]) - 3;
    m  = sh >= 0 ? pm >> sh : pm << (-sh);
    r  = ((ma < 0) != (mb < 0)) ? 32'(-m) : 32'(m);
    e.ovf = m >= 4096;
    e.p   = e.ovf ? 16'h0000 : {r[12:0], 3'd3};
    return e;
  endfunction
  task automatic wait_result(input string name);
    exp_t e;
    int n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " latency"}, n, 14);
    if (sb.size() == 0) begin
      chk({name, " scoreboard"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({name, " P"}, {16'h0, p}, {16'h0, e.p});
    chk({name, " overFlow"}, {31'h0, overflow}, {31'h0, e.ovf});
  endtask
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ep,
                       input logic eo, input bit poke, input string name);
    exp_t e;
    exp_t q;
    int n = 0;
    @(negedge clk);
    mcand = a; mplier = b; start = 1'b1;
    e.p = ep; e.ovf = eo;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    mcand = 16'($urandom); mplier = 16'($urandom);
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (poke && n == 4) begin start = 1'b1; mcand = 16'h0320; mplier = 16'h0320; end
      if (poke && n == 5) start = 1'b0;
    end
    chk({name, " latency"}, n, 14);
    if (sb.size() == 0) begin
      chk({name, " scoreboard"}, 0, 1);
      return;
    end
    q = sb.pop_front();
    chk({name, " P"}, {16'h0, p}, {16'h0, q.p});
    chk({name, " overFlow"}, {31'h0, overflow}, {31'h0, q.ovf});
  endtask
  initial begin
    exp_t e;
    logic [15:0] ra, rb;
    tv[0]  = '{16'h00A3, 16'h0063, 16'h00F3, 1'b0};
    tv[1]  = '{16'hFF63, 16'h0063, 16'hFF13, 1'b0};
    tv[2]  = '{16'hFF63, 16'hFFA3, 16'h00F3, 1'b0};
    tv[3]  = '{16'h00A3, 16'hFFA3, 16'hFF13, 1'b0};
    tv[4]  = '{16'h0018, 16'h0013, 16'h0033, 1'b0};
    tv[5]  = '{16'h0018, 16'h0028, 16'h03C3, 1'b0};
    tv[6]  = '{16'h0320, 16'h0320, 16'h0000, 1'b1};
    tv[7]  = '{16'h0000, 16'h7FF8, 16'h0003, 1'b0};
    tv[8]  = '{16'hFFF8, 16'h0000, 16'h0003, 1'b0};
    tv[9]  = '{16'h8000, 16'h000B, 16'h0000, 1'b1};
    tv[10] = '{16'h8007, 16'h0008, 16'hF803, 1'b0};
    tv[11] = '{16'hFFFF, 16'h0017, 16'h0003, 1'b0};
    tv[12] = '{16'hFFCB, 16'h0063, 16'hFFB3, 1'b0};
    reset = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset P", {16'h0, p}, 32'h0);
    chk("reset ready", {31'h0, ready}, 32'h0);
    chk("reset overFlow", {31'h0, overflow}, 32'h0);
    reset = 1'b0;
    foreach (tv[i])
      do_op(tv[i].a, tv[i].b, tv[i].p, tv[i].ovf, i == 4, $sformatf("vec%0d", i));
    // abort mid-operation: extra start ignored, then reset, then a fresh op
    @(negedge clk);
    mcand = 16'h0320; mplier = 16'h0018; start = 1'b1;
    e.p = 16'h0000; e.ovf = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort P", {16'h0, p}, 32'h0);
    chk("abort ready", {31'h0, ready}, 32'h0);
    @(posedge clk); #1;
    chk("abort P k+7", {16'h0, p}, 32'h0);
    chk("abort ready k+7", {31'h0, ready}, 32'h0);
    chk("abort overFlow k+7", {31'h0, overflow}, 32'h0);
    sb.delete();
    mcand = 16'h00A3; mplier = 16'h0063; start = 1'b1;
    e.p = 16'h00F3; e.ovf = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    wait_result("restart");
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      e = model(ra, rb);
      do_op(ra, rb, e.p, e.ovf, 1'b0, $sformatf("rand%0d", i));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
